// File: rtl/traffic_countdown_display.sv
// traffic_countdown_display: phase countdown with a two-digit multiplexed 7-seg display, lamp pass-through and a sticky fault.
module traffic_countdown_display #(
    parameter int SCAN_DIV = 50000,
    parameter int DUR_A    = 5,
    parameter int DUR_B    = 121,
    parameter int DUR_C    = 5,
    parameter int DUR_D    = 2,
    parameter int DUR_E    = 30,
    parameter int DUR_F    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [2:0] phase,
    input  logic [5:0] lamps,
    output logic [5:0] lamp_out,
    output logic [7:0] remaining,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       fault
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [5:0] ALL_RED = 6'b100100;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH = 7'b0111111;

    typedef enum logic [1:0] {S_OFF, S_ONES, S_TENS} scan_state_t;

    scan_state_t state_q, state_d;
    logic [2:0] phase_q;
    logic [7:0] remaining_q, remaining_d;
    logic fault_q, fault_d;
    logic [5:0] lamp_out_q, lamp_out_d;
    logic [6:0] seg_q, seg_d;
    logic [1:0] dig_en_q, dig_en_d;
    logic [CW-1:0] scan_q, scan_d;
    logic phase_bad, phase_chg, lamp_bad, scan_wrap;
    logic [6:0] disp;
    logic [3:0] tens, ones;

    function automatic logic [7:0] dur(input logic [2:0] p);
        case (p)
            3'd0: return 8'(DUR_A);
            3'd1: return 8'(DUR_B);
            3'd2: return 8'(DUR_C);
            3'd3: return 8'(DUR_D);
            3'd4: return 8'(DUR_E);
            3'd5: return 8'(DUR_F);
            default: return 8'd0;
        endcase
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs for decimal digits.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return ~7'h3F;
            4'd1: return ~7'h06;
            4'd2: return ~7'h5B;
            4'd3: return ~7'h4F;
            4'd4: return ~7'h66;
            4'd5: return ~7'h6D;
            4'd6: return ~7'h7D;
            4'd7: return ~7'h07;
            4'd8: return ~7'h7F;
            4'd9: return ~7'h6F;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic one_hot(input logic [2:0] v);
        return v == 3'b001 || v == 3'b010 || v == 3'b100;
    endfunction

    // Next-state for countdown, fault, lamps, scan position and the digit pattern of the slot being entered.
    always_comb begin
        phase_bad = phase > 3'd5;
        phase_chg = phase != phase_q;
        lamp_bad = !one_hot(lamps[5:3]) || !one_hot(lamps[2:0]);
        fault_d = fault_q || phase_bad || lamp_bad;
        remaining_d = phase_bad ? 8'd0
                    : phase_chg ? dur(phase)
                    : tick ? (remaining_q == 8'd0 ? 8'd0 : remaining_q - 8'd1)
                    : remaining_q;
        lamp_out_d = fault_d ? ALL_RED : lamps;
        scan_wrap = scan_q == CW'(SCAN_DIV - 1);
        scan_d = (state_q == S_OFF || scan_wrap) ? '0 : scan_q + 1'b1;
        state_d = state_q == S_OFF ? S_ONES
                : scan_wrap ? (state_q == S_ONES ? S_TENS : S_ONES)
                : state_q;
        disp = remaining_d > 8'd99 ? 7'd99 : remaining_d[6:0];
        tens = 4'(disp / 7'd10);
        ones = 4'(disp - 7'(tens) * 7'd10);
        seg_d = fault_d ? DASH
              : state_d == S_TENS ? (tens == 4'd0 ? BLANK : glyph(tens))
              : glyph(ones);
        dig_en_d = state_d == S_TENS ? 2'b01 : 2'b10;
    end

    // All state and registered outputs; reset forces the safe all-red, blank display condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            phase_q <= 3'b111;
            remaining_q <= 8'd0;
            fault_q <= 1'b0;
            lamp_out_q <= ALL_RED;
            seg_q <= BLANK;
            dig_en_q <= 2'b11;
            scan_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase;
            remaining_q <= remaining_d;
            fault_q <= fault_d;
            lamp_out_q <= lamp_out_d;
            seg_q <= seg_d;
            dig_en_q <= dig_en_d;
            scan_q <= scan_d;
        end
    end

    assign lamp_out = lamp_out_q;
    assign remaining = remaining_q;
    assign seg = seg_q;
    assign dig_en = dig_en_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb_traffic_countdown_display: scoreboard bench for the countdown display with a fast scan divider.
module tb_traffic_countdown_display;
    localparam int DIV = 4;
    localparam logic [5:0] OK_A = 6'b100001;
    localparam logic [5:0] OK_B = 6'b001100;
    localparam logic [23:0] RST_EXP = {6'b100100, 8'd0, 1'b0, 7'h7F, 2'b11};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic [2:0] phase = 3'd0;
    logic [5:0] lamps = OK_A;
    logic [5:0] lamp_out;
    logic [7:0] remaining;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic fault;

    traffic_countdown_display #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .phase(phase), .lamps(lamps),
        .lamp_out(lamp_out), .remaining(remaining), .seg(seg), .dig_en(dig_en), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got, e;
    logic [6:0] pat[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int durs[6] = '{5, 121, 5, 2, 30, 5};
    int m_pq, m_rem, m_cnt, m_dig, m_run;
    bit m_fault;

    function automatic logic [23:0] obs();
        return {lamp_out, remaining, fault, seg, dig_en};
    endfunction

    task automatic m_reset();
        m_pq = 7; m_rem = 0; m_fault = 0; m_run = 0; m_cnt = 0; m_dig = 0;
    endtask

    // Drives one cycle from a falling edge, predicts the registered outputs, samples after the rising edge.
    task automatic drive(input bit t, input int ph, input logic [5:0] lm);
        bit inv, chg, bad;
        int v;
        logic [6:0] s;
        tick = t; phase = 3'(ph); lamps = lm;
        inv = ph > 5;
        chg = ph != m_pq;
        bad = $countones(lm[5:3]) != 1 || $countones(lm[2:0]) != 1;
        m_fault = m_fault | inv | bad;
        if (inv) m_rem = 0;
        else if (chg) m_rem = durs[ph];
        else if (t && m_rem > 0) m_rem = m_rem - 1;
        m_pq = ph;
        if (!m_run) begin
            m_run = 1; m_cnt = 0; m_dig = 0;
        end else begin
            if (m_cnt == DIV - 1) m_dig = m_dig ^ 1;
            m_cnt = (m_cnt + 1) % DIV;
        end
        v = m_rem > 99 ? 99 : m_rem;
        s = m_fault ? 7'b0111111 : m_dig != 0 ? (v / 10 == 0 ? 7'h7F : ~pat[v / 10]) : ~pat[v % 10];
        exp_q.push_back({m_fault ? 6'b100100 : lm, 8'(m_rem), m_fault, s, m_dig != 0 ? 2'b01 : 2'b10});
        @(posedge clk);
        #1 got = obs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        exp_q.push_back(RST_EXP);
        got = obs();
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, e); end
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL reset_release[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_countdown();
        for (int i = 0; i < 130; i++) begin
            drive(i > 0 && i < 126, 1, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL countdown[%0d] got=%h exp=%h", i, got, e); end
        end
        if (remaining !== 8'd0) begin failures++; $display("FAIL countdown_floor got=%0d exp=0", remaining); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int ph_t[12] = '{1, 2, 2, 2, 3, 3, 3, 3, 4, 4, 5, 5};
        bit tk_t[12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 12; i++) begin
            drive(tk_t[i], ph_t[i], OK_B);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_scan();
        drive(0, 4, OK_A);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL scan_load got=%h exp=%h", got, e); end
        for (int i = 0; i < 16; i++) begin
            drive(0, 4, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e || dig_en === 2'b00) begin failures++; $display("FAIL scan[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_lamp_fault();
        drive(0, 4, 6'b110100);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL lamp_fault_set got=%h exp=%h", got, e); end
        for (int i = 0; i < 8; i++) begin
            drive(i[0], i < 4 ? 4 : 5, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL lamp_fault_sticky[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_invalid_phase();
        rst_n = 1'b0;
        #1 got = obs();
        exp_q.push_back(RST_EXP);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL async_reset_a got=%h exp=%h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i == 4, i == 2 ? 6 : 0, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL invalid_phase[%0d] got=%h exp=%h", i, got, e); end
        end
        rst_n = 1'b0;
        #1 got = obs();
        exp_q.push_back(RST_EXP);
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin failures++; $display("FAIL async_reset_b got=%h exp=%h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 7, OK_A);
            e = exp_q.pop_front(); checks++;
            if (got !== e) begin failures++; $display("FAIL phase7[%0d] got=%h exp=%h", i, got, e); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        m_reset();
        test_reset();
        test_countdown();
        test_back_to_back();
        test_scan();
        test_lamp_fault();
        test_invalid_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
